// File: rtl/spi_rx_ip_top.sv
// spi_rx_ip_top: SPI byte receiver with input synchronizers, dc tagging,
// sticky framing/overrun flags and a first-word fall-through FIFO.
module spi_rx_ip_top #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       dc,
    input  logic       scl,
    input  logic       sda,
    input  logic       rx_ready,
    input  logic       clear,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SYNC_STAGES:0]   cs_q, cs_d, scl_q, scl_d;
    logic [SYNC_STAGES-1:0] sda_q, sda_d, dc_q, dc_d;
    logic [0:0]             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [8:0]             mem_q [FIFO_DEPTH];
    logic [8:0]             mem_d [FIFO_DEPTH];
    logic [AW:0]            wp_q, wp_d, rp_q, rp_d;
    logic                   overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                   cs_rise, cs_fall, scl_rise, sda_s, dc_s;
    logic                   push, pop, wr, full, empty, frame_set;

    always_comb begin
        cs_d     = {cs_q[SYNC_STAGES-1:0], cs};
        scl_d    = {scl_q[SYNC_STAGES-1:0], scl};
        sda_d    = {sda_q[SYNC_STAGES-2:0], sda};
        dc_d     = {dc_q[SYNC_STAGES-2:0], dc};
        cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
        cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
        scl_rise = scl_q[SYNC_STAGES-1] & ~scl_q[SYNC_STAGES];
        sda_s    = sda_q[SYNC_STAGES-1];
        dc_s     = dc_q[SYNC_STAGES-1];
    end

    // A cs release wins over a coincident scl rise: the partial byte is dropped.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d   = RECV;
                bit_cnt_d = 3'd0;
                shift_d   = 7'd0;
            end
        end else if (cs_rise) begin
            state_d   = IDLE;
            frame_set = bit_cnt_q != 3'd0;
        end else if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            push      = bit_cnt_q == 3'd7;
        end
    end

    always_comb begin
        empty       = wp_q == rp_q;
        full        = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop         = rx_ready && !empty;
        wr          = push && (!full || pop);
        mem_d       = mem_q;
        if (wr) mem_d[wp_q[AW-1:0]] = {dc_s, shift_q, sda_s};
        wp_d        = wr ? wp_q + PTR_ONE : wp_q;
        rp_d        = pop ? rp_q + PTR_ONE : rp_q;
        overrun_d   = (push && full && !pop) || (overrun_q && !clear);
        frame_err_d = frame_set || (frame_err_q && !clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q        <= '0;
            scl_q       <= '0;
            sda_q       <= '0;
            dc_q        <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wp_q        <= '0;
            rp_q        <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            dc_q        <= dc_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = mem_q[rp_q[AW-1:0]][7:0];
    assign rx_dc     = mem_q[rp_q[AW-1:0]][8];
    assign rx_valid  = !empty;
    assign busy      = state_q == RECV;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_rx_ip_top.sv
// tb_spi_rx_ip_top: directed and randomized SPI frames checked every cycle
// against a transaction-level model of the receiver.
module tb_spi_rx_ip_top;
    localparam int S = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset, cs, dc, scl, sda, rx_ready, clear;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, busy, overrun, frame_err;

    spi_rx_ip_top #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cs(cs), .dc(dc), .scl(scl), .sda(sda),
        .rx_ready(rx_ready), .clear(clear), .rx_data(rx_data), .rx_dc(rx_dc),
        .rx_valid(rx_valid), .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Events the driver predicts, keyed by the clk edge that makes them visible.
    logic [8:0] ev_byte [int];
    bit         ev_busy [int];
    bit         ev_frame[int];
    logic [8:0] mq[$];
    bit         m_busy, m_over, m_frame, m_fresh;
    bit         set_o, set_f;
    int         e_now;

    bit         recv = 0;
    int         bits = 0;
    logic [7:0] sh = 8'h00;
    bit         rdy_hold = 0, rnd_rdy = 0, rnd_clr = 0, pop_on_push = 0, clear_on_push = 0;
    int         pop_at = -1, clear_at = -1;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            ev_byte.delete();
            ev_busy.delete();
            ev_frame.delete();
            m_busy  = 0;
            m_over  = 0;
            m_frame = 0;
            m_fresh = 1;
        end else begin
            e_now = cyc + 1;
            if (rx_ready && mq.size() > 0) mq.delete(0);
            set_o = 0;
            if (ev_byte.exists(e_now)) begin
                if (mq.size() < D) begin
                    mq.push_back(ev_byte[e_now]);
                    m_fresh = 0;
                end else set_o = 1;
                ev_byte.delete(e_now);
            end
            set_f = ev_frame.exists(e_now);
            if (set_f) ev_frame.delete(e_now);
            if (ev_busy.exists(e_now)) begin
                m_busy = ev_busy[e_now];
                ev_busy.delete(e_now);
            end
            m_over  = set_o ? 1'b1 : clear ? 1'b0 : m_over;
            m_frame = set_f ? 1'b1 : clear ? 1'b0 : m_frame;
        end
    end

    always @(negedge clk) begin
        #1;
        chk("rx_valid", 9'(rx_valid), 9'(mq.size() > 0));
        if (mq.size() > 0) chk("rx_head", {rx_dc, rx_data}, mq[0]);
        else if (m_fresh) chk("rx_head_rst", {rx_dc, rx_data}, 9'h000);
        chk("busy", 9'(busy), 9'(m_busy));
        chk("overrun", 9'(overrun), 9'(m_over));
        chk("frame_err", 9'(frame_err), 9'(m_frame));
    end

    always @(posedge clk) begin
        #1;
        rx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : (rdy_hold || (cyc + 1 == pop_at));
        clear    = (cyc + 1 == clear_at) || (rnd_clr && $urandom_range(0, 15) == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        if (cs) begin
            cs = 1'b0;
            ev_busy[cyc + 1 + S] = 1'b1;
            recv = 1;
            bits = 0;
            sh   = 8'h00;
        end
        tick(6);
    endtask

    task automatic cs_high();
        if (!cs) begin
            cs = 1'b1;
            if (recv) begin
                ev_busy[cyc + 1 + S] = 1'b0;
                if (bits != 0) ev_frame[cyc + 1 + S] = 1'b1;
            end
            recv = 0;
        end
        tick(6);
    endtask

    task automatic send_bit(input logic b);
        int key;
        sda = b;
        tick(4);
        scl = 1'b1;
        if (recv) begin
            sh = {sh[6:0], b};
            bits++;
            if (bits == 8) begin
                key = cyc + 1 + S;
                ev_byte[key] = {dc, sh};
                if (pop_on_push) pop_at = key;
                if (clear_on_push) clear_at = key;
                bits = 0;
            end
        end
        tick(4);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dcv);
        dc = dcv;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic pop_expect(input string nm, input logic [8:0] exp);
        chk({nm, "_valid"}, 9'(rx_valid), 9'h001);
        chk(nm, {rx_dc, rx_data}, exp);
        pop_at = cyc + 2;
        tick(2);
    endtask

    task automatic clear_pulse();
        clear_at = cyc + 2;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b1; dc = 1'b0; scl = 1'b0; sda = 1'b0;
        rx_ready = 1'b0; clear = 1'b0;
        tick(3);
        chk("rst_all", {rx_valid, busy, overrun, frame_err, 5'd0}, 9'h000);
        chk("rst_data", {rx_dc, rx_data}, 9'h000);
        reset = 1'b0;
        tick(8);

        cs_low();
        chk("t1_busy", 9'(busy), 9'h001);
        send_byte(8'hA5, 1'b1);
        chk("t1_head", {rx_dc, rx_data}, 9'h1A5);
        cs_high();
        chk("t1_flags", {busy, overrun, frame_err}, 9'h000);
        pop_expect("t1_pop", 9'h1A5);
        chk("t1_empty", 9'(rx_valid), 9'h000);

        cs_low();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        cs_high();
        pop_expect("t2_pop0", 9'h03C);
        pop_expect("t2_pop1", 9'h0C3);
        chk("t2_empty", 9'(rx_valid), 9'h000);

        cs_low();
        dc = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        cs_high();
        chk("t3_frame", 9'(frame_err), 9'h001);
        chk("t3_empty", 9'(rx_valid), 9'h000);
        cs_low();
        send_byte(8'h81, 1'b1);
        cs_high();
        pop_expect("t3_pop", 9'h181);
        chk("t3_empty2", 9'(rx_valid), 9'h000);
        clear_pulse();
        chk("t3_clear", 9'(frame_err), 9'h000);

        cs_low();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        cs_high();
        chk("t4_over", 9'(overrun), 9'h001);
        for (int i = 1; i <= 4; i++) pop_expect("t4_pop", {1'b1, 8'(i)});
        chk("t4_empty", 9'(rx_valid), 9'h000);
        clear_pulse();
        chk("t4_clear", 9'(overrun), 9'h000);
        cs_low();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        pop_on_push = 1;
        send_byte(8'h05, 1'b1);
        pop_on_push = 0;
        cs_high();
        chk("t4b_over", 9'(overrun), 9'h000);
        for (int i = 2; i <= 5; i++) pop_expect("t4b_pop", {1'b1, 8'(i)});

        cs_low();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
        clear_on_push = 1;
        send_byte(8'h66, 1'b0);
        clear_on_push = 0;
        cs_high();
        chk("t5_over", 9'(overrun), 9'h001);
        for (int i = 0; i < 4; i++) pop_expect("t5_pop", {1'b0, 8'(8'h10 + i)});
        clear_pulse();

        cs_low();
        dc = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        recv  = 0;
        tick(2);
        chk("t6_rst", {rx_valid, busy, overrun, frame_err, rx_dc, 4'd0}, 9'h000);
        chk("t6_rst_data", 9'(rx_data), 9'h000);
        reset = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        chk("t6_idle", {rx_valid, busy, overrun, frame_err, 5'd0}, 9'h000);
        cs_high();
        cs_low();
        send_byte(8'h5A, 1'b1);
        cs_high();
        pop_expect("t6_pop", 9'h15A);

        rnd_rdy = 1;
        rnd_clr = 1;
        for (int f = 0; f < 40; f++) begin
            cs_low();
            for (int b = 0; b < int'($urandom_range(1, 4)); b++)
                send_byte(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 3)
                for (int k = 0; k < int'($urandom_range(1, 7)); k++) send_bit(1'($urandom_range(0, 1)));
            cs_high();
        end
        rnd_rdy = 0;
        rnd_clr = 0;
        rdy_hold = 1;
        tick(8);
        rdy_hold = 0;
        tick(2);
        chk("final_empty", 9'(rx_valid), 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
